fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fq_pkg.sv | 21 ++
 rtl/fq_storage.sv | 27 ++
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fq_pkg.sv
// Shared types and constants for the fetch queue: entry layout, instruction-memory window, default depth.
// Also holds the fetch address-error rule so the queue and any neighbour agree on it.
package fq_pkg;

  localparam int unsigned FQ_DEPTH = 4;

  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fq_entry_t;

  // AdEL: misaligned word fetch or a PC outside the instruction-memory window.
  function automatic logic fetch_addr_err(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);
  endfunction

endpackage

// File: rtl/fq_storage.sv
// DEPTH x entry register array: one synchronous write port, one combinational read port.
// Zero-cycle read latency; no flow control of its own, the owner gates the write enable.
module fq_storage
  import fq_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  fq_entry_t                wr_dat_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output fq_entry_t                rd_dat_o
);

  fq_entry_t mem_q [DEPTH];

  // Contents are never reset; the owner masks unoccupied entries.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue; push visible at outputs one cycle later (no bypass).
// in_ready depends only on occupancy; flush empties the queue and wins over push/pop.
module fetch_queue
  import fq_pkg::*;
#(
  parameter int unsigned DEPTH    = FQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic                   out_exc,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic      push;
  logic      pop;
  logic      wr_en;
  fq_entry_t wr_dat;
  fq_entry_t head_ent;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  assign wr_en        = push && !flush && !reset;
  assign wr_dat.pc    = in_pc;
  assign wr_dat.instr = in_instr;
  assign wr_dat.exc   = fetch_addr_err(in_pc);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (tail_q),
    .wr_dat_i  (wr_dat),
    .rd_addr_i (head_q),
    .rd_dat_o  (head_ent)
  );

  // Stale storage must never leak out while empty.
  always_comb begin
    if (out_valid) begin
      out_pc    = head_ent.pc;
      out_instr = head_ent.instr;
      out_exc   = head_ent.exc;
    end else begin
      out_pc    = RESET_PC;
      out_instr = '0;
      out_exc   = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: entries queued on accepted pushes, compared at the head each cycle.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_exc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RPC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_exc   (out_exc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  function automatic logic exp_exc(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFF);
  endfunction

  task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl, input bit rst);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    bit   push;
    bit   pop;
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("empty_vld", 32'(out_valid), 32'd0);
      check_eq("empty_pc", out_pc, RPC);
      check_eq("empty_instr", out_instr, 32'd0);
      check_eq("empty_exc", 32'(out_exc), 32'd0);
    end else begin
      check_eq("head_vld", 32'(out_valid), 32'd1);
      check_eq("head_pc", out_pc, sb[0].pc);
      check_eq("head_instr", out_instr, sb[0].instr);
      check_eq("head_exc", 32'(out_exc), 32'(sb[0].exc));
    end
    check_eq("count", 32'(count), 32'(sb.size()));
    check_eq("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
    push = in_valid && (sb.size() != DEPTH);
    pop  = (sb.size() != 0) && out_ready;
    @(posedge clk);
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (pop) sb.delete(0);
      if (push) begin
        e.pc    = in_pc;
        e.instr = in_instr;
        e.exc   = exp_exc(in_pc);
        sb.push_back(e);
      end
    end
    #1;
  endtask

  initial begin
    drive(0, 32'd0, 0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    drive(0, 32'd0, 0, 0, 0);
    repeat (2) cycle();

    // Fill to full, offer one more, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 0, 0, 0);
      cycle();
    end
    drive(1, 32'h0000_3010, 0, 0, 0);
    cycle();
    check_eq("full_count", 32'(count), 32'd4);
    check_eq("full_ready", 32'(in_ready), 32'd0);
    drive(0, 32'd0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_pc", out_pc, 32'h3000 + 32'(4 * i));
      cycle();
    end
    check_eq("drained_count", 32'(count), 32'd0);

    // Streaming at one entry per cycle; pointers wrap several times.
    for (int i = 0; i < 16; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 1, 0, 0);
      cycle();
      check_eq("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
      check_eq("stream_count", 32'(count), 32'd1);
    end
    drive(0, 32'd0, 1, 0, 0);
    cycle();

    // Flush beats a same-cycle push and pop.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3100 + 32'(4 * i), 0, 0, 0);
      cycle();
    end
    drive(1, 32'h0000_3020, 1, 1, 0);
    cycle();
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_vld", 32'(out_valid), 32'd0);
    check_eq("flush_ready", 32'(in_ready), 32'd1);
    drive(0, 32'd0, 1, 0, 0);
    repeat (2) cycle();

    // Address-error flag: misaligned, out of window, good.
    drive(1, 32'h0000_3002, 0, 0, 0); cycle();
    drive(1, 32'h0000_7000, 0, 0, 0); cycle();
    drive(1, 32'h0000_3004, 0, 0, 0); cycle();
    drive(0, 32'd0, 1, 0, 0);
    check_eq("exc_misalign", 32'(out_exc), 32'd1);
    cycle();
    check_eq("exc_range", 32'(out_exc), 32'd1);
    cycle();
    check_eq("exc_ok", 32'(out_exc), 32'd0);
    cycle();
    cycle();

    // Reset while full overrides flush, push and pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3200 + 32'(4 * i), 0, 0, 0);
      cycle();
    end
    drive(1, 32'h0000_3040, 1, 1, 1);
    cycle();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    check_eq("rst_vld", 32'(out_valid), 32'd0);
    check_eq("rst_pc", out_pc, RPC);
    drive(0, 32'd0, 1, 0, 0);
    repeat (2) cycle();

    // Random traffic with occasional flushes and bad PCs.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0,
            32'h0000_2FF0 + 32'($urandom_range(0, 32'h4020)),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0,
            0);
      cycle();
    end
    drive(0, 32'd0, 1, 0, 0);
    repeat (5) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
